// File: rtl/uart_secded_pkg.sv
// Shared types and ECC helpers for the UART SECDED receive path.
package uart_secded_pkg;

  // Receiver framing states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_t;

  // Outcome of decoding one codeword.
  typedef enum logic [1:0] {
    ECC_CLEAN         = 2'd0,
    ECC_CORRECTED     = 2'd1,
    ECC_UNCORRECTABLE = 2'd2
  } ecc_class_t;

  // Data bits per serial frame: 7 for Hamming(7,4), 8 when the overall parity bit is added.
  function automatic int code_w(input int extended);
    return (extended != 0) ? 8 : 7;
  endfunction

  // Codeword bit i is Hamming position i+1 (p1 p2 d1 p3 d2 d3 d4); result is {s3,s2,s1}.
  function automatic logic [2:0] hamming_syndrome(input logic [6:0] cw);
    logic s1, s2, s3;
    s1 = cw[0] ^ cw[2] ^ cw[4] ^ cw[6];
    s2 = cw[1] ^ cw[2] ^ cw[5] ^ cw[6];
    s3 = cw[3] ^ cw[4] ^ cw[5] ^ cw[6];
    return {s3, s2, s1};
  endfunction

  // Plain Hamming trusts any non-zero syndrome; SECDED uses the overall parity to
  // tell a single error (parity bad) from a double error (parity good, syndrome set).
  function automatic ecc_class_t secded_classify(input logic [2:0] syndrome,
                                                 input logic       parity_bad,
                                                 input logic       extended);
    ecc_class_t cls;
    cls = ECC_CLEAN;
    if (!extended) begin
      if (syndrome != 3'd0) cls = ECC_CORRECTED;
    end else if (parity_bad) begin
      cls = ECC_CORRECTED;
    end else if (syndrome != 3'd0) begin
      cls = ECC_UNCORRECTABLE;
    end
    return cls;
  endfunction

  // Extract d1..d4 into nibble bits 0..3.
  function automatic logic [3:0] hamming_data(input logic [6:0] cw);
    return {cw[6], cw[5], cw[4], cw[2]};
  endfunction

endpackage

// File: rtl/rx_word_fifo.sv
// Synchronous word FIFO with occupancy count; a pop frees room for a same-cycle push.
module rx_word_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     dropped
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_pop;
  logic             do_push;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dropped = push & full & ~do_pop;
  // Empty FIFO presents an all-zero head so downstream flags never show stale data.
  assign head    = empty ? '0 : mem[rd_ptr];

  // Storage array; contents are only meaningful below the count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_secded_rx.sv
// Oversampling UART receiver that decodes Hamming/SECDED nibbles and buffers assembled words.
//
// Output handshake: word_out/err_* describe the FIFO head while word_valid is high;
// the word is consumed on any clock edge where word_valid and word_ready are both high,
// and the next entry (or zeros when empty) appears on the following cycle.
module uart_secded_rx
  import uart_secded_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8,
  parameter int EXTENDED     = 1,
  parameter int DATA_NIBBLES = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ena,
  input  logic                          rx,
  output logic [4*DATA_NIBBLES-1:0]     word_out,
  output logic                          word_valid,
  input  logic                          word_ready,
  output logic                          err_corrected,
  output logic                          err_uncorrectable,
  output logic                          frame_err,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int W      = 4 * DATA_NIBBLES;
  localparam int CW     = code_w(EXTENDED);
  localparam int CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int NIB_W  = (DATA_NIBBLES > 1) ? $clog2(DATA_NIBBLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [2:0]       BIT_LAST = 3'(CW - 1);

  // Synchroniser and edge history.
  logic rx_meta;
  logic rx_sync;
  logic rx_prev;

  // Framing FSM.
  rx_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [CW-1:0]    shreg;
  logic [CW-1:0]    cw_reg;
  logic             dec_strobe;

  // Decoder.
  logic [2:0]  syndrome;
  ecc_class_t  ecc_cls;
  logic [6:0]  fixed;
  logic [3:0]  nibble;

  // Assembler.
  logic [NIB_W-1:0] nib_cnt;
  logic [W-1:0]     acc_word;
  logic             acc_corr;
  logic             acc_unc;
  logic [W-1:0]     asm_word;
  logic             asm_corr;
  logic             asm_unc;
  logic             last_nib;
  logic             push;

  // FIFO side.
  logic [W+1:0]     fifo_head;
  logic             fifo_empty;
  logic             fifo_dropped;

  // Two-flop synchroniser; resets to the idle-high line level so reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // Framing FSM: start-bit qualification, mid-bit data sampling, stop-bit check.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      cw_reg     <= '0;
      dec_strobe <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      dec_strobe <= 1'b0;
      frame_err  <= 1'b0;
      if (!ena) begin
        state   <= ST_IDLE;
        cnt     <= '0;
        bit_idx <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (!rx_sync && rx_prev) begin
              state <= ST_START;
              cnt   <= '0;
            end
          end
          ST_START: begin
            if (cnt == CNT_HALF) begin
              cnt     <= '0;
              bit_idx <= '0;
              state   <= rx_sync ? ST_IDLE : ST_DATA;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_DATA: begin
            if (cnt == CNT_LAST) begin
              cnt   <= '0;
              shreg <= {rx_sync, shreg[CW-1:1]};
              if (bit_idx == BIT_LAST) state <= ST_STOP;
              else                     bit_idx <= bit_idx + 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_STOP: begin
            if (cnt == CNT_LAST) begin
              cnt   <= '0;
              state <= ST_IDLE;
              if (rx_sync) begin
                cw_reg     <= shreg;
                dec_strobe <= 1'b1;
              end else begin
                frame_err <= 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Decode the latched codeword; only single errors at a data/parity position get flipped.
  always_comb begin
    syndrome = hamming_syndrome(cw_reg[6:0]);
    ecc_cls  = secded_classify(syndrome, ^cw_reg, EXTENDED != 0);
    fixed    = cw_reg[6:0];
    if (ecc_cls == ECC_CORRECTED && syndrome != 3'd0)
      fixed[syndrome - 3'd1] = ~fixed[syndrome - 3'd1];
    nibble = hamming_data(fixed);
  end

  // Merge the decoded nibble into the partial word; the last nibble produces a push.
  always_comb begin
    asm_word = acc_word;
    asm_word[int'(nib_cnt) * 4 +: 4] = nibble;
    asm_corr = acc_corr | (ecc_cls == ECC_CORRECTED);
    asm_unc  = acc_unc  | (ecc_cls == ECC_UNCORRECTABLE);
    last_nib = (int'(nib_cnt) == DATA_NIBBLES - 1);
    push     = dec_strobe & ena & last_nib;
  end

  // Partial-word state; disable or a framing error throws the partial word away.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      nib_cnt  <= '0;
      acc_word <= '0;
      acc_corr <= 1'b0;
      acc_unc  <= 1'b0;
    end else if (!ena || frame_err) begin
      nib_cnt  <= '0;
      acc_word <= '0;
      acc_corr <= 1'b0;
      acc_unc  <= 1'b0;
    end else if (dec_strobe) begin
      if (last_nib) begin
        nib_cnt  <= '0;
        acc_word <= '0;
        acc_corr <= 1'b0;
        acc_unc  <= 1'b0;
      end else begin
        nib_cnt  <= nib_cnt + 1'b1;
        acc_word <= asm_word;
        acc_corr <= asm_corr;
        acc_unc  <= asm_unc;
      end
    end
  end

  rx_word_fifo #(
    .WIDTH (W + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({asm_unc, asm_corr, asm_word}),
    .pop       (word_ready),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .dropped   (fifo_dropped)
  );

  assign word_out          = fifo_head[W-1:0];
  assign err_corrected     = fifo_head[W];
  assign err_uncorrectable = fifo_head[W+1];
  assign word_valid        = ~fifo_empty;

  // Sticky record that a completed word was lost to a full FIFO.
  always_ff @(posedge clk) begin
    if (!rst_n)            overflow <= 1'b0;
    else if (fifo_dropped) overflow <= 1'b1;
  end

endmodule

// File: doc/uart_secded_rx.md
# uart_secded_rx

Parametrised successor to the UART-fed Hamming(7,4) receive path. It oversamples a serial `rx` line and frames 7-bit Hamming(7,4) or 8-bit SECDED(8,4) codewords. Each codeword is decoded and corrected, and the resulting nibbles are assembled into multi-nibble words. Completed words and their error flags are buffered in a FIFO and delivered downstream through a valid/ready handshake. The block sits between the top-level `ui_in[0]` serial pin and downstream consumers or the debug output mux.

## Interface
Parameters:
- `CLKS_PER_BIT`, 8: clocks per UART bit; must be even and ≥ 4.
- `EXTENDED`, 1: 0 = Hamming(7,4), 7 data bits per frame; 1 = SECDED(8,4), 8 data bits per frame.
- `DATA_NIBBLES`, 2: nibbles per output word; `W = 4*DATA_NIBBLES`.
- `FIFO_DEPTH`, 4: word FIFO entries; must be a power of 2 and ≥ 2.

Ports:
- `clk`  in  1  single clock; the only clock in the block.
- `rst_n`  in  1  reset; synchronous and active-low.
- `ena`  in  1  receiver enable; low aborts the current frame and holds the FSM in IDLE.
- `rx`  in  1  serial input; idles high; 8N1-style framing with `7+EXTENDED` data bits, LSB first.
- `word_out`  out  W  head FIFO word; first received nibble in bits [3:0].
- `word_valid`  out  1  FIFO is non-empty.
- `word_ready`  in  1  consumer accepts the word; a pop occurs when `word_valid & word_ready`.
- `err_corrected`  out  1  head word contained at least one corrected nibble.
- `err_uncorrectable`  out  1  head word contained at least one double-error nibble (EXTENDED=1 only).
- `frame_err`  out  1  one-cycle pulse when a stop bit is sampled low.
- `overflow`  out  1  sticky; set when a completed word is dropped; cleared only by reset.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  current occupancy.

## Operation
- `rx` passes through a 2-flop synchroniser (reset value 1). All sampling uses the synchronised signal.
- FSM states:
  - IDLE: a falling edge moves to START.
  - START: at count `CLKS_PER_BIT/2`, a high line returns to IDLE (glitch); a low line moves to DATA.
  - DATA: samples `7+EXTENDED` bits, each `CLKS_PER_BIT` clocks after the previous sample.
  - STOP: samples once. A high stop bit triggers a decode strobe. A low stop bit raises `frame_err`, discards the codeword and partial word, and clears the nibble count. Either way, the FSM returns to IDLE.
- Codeword bit i corresponds to Hamming position i+1: p1 p2 d1 p3 d2 d3 d4. Data mapping is d1..d4 = nibble[0..3]. Bit 7 (EXTENDED=1) is overall even parity.
- Syndrome is `{s3,s2,s1}`, where s1 = XOR of positions 1,3,5,7; s2 = XOR of 2,3,6,7; s3 = XOR of 4,5,6,7.
- Decode rules, EXTENDED=0:
  - Syndrome ≠ 0: flip that position and mark the nibble corrected.
  - Syndrome = 0: nibble is clean.
- Decode rules, EXTENDED=1 (P = overall parity check):
  - Syndrome 0, P ok: clean.
  - P bad: single error; correct it. Syndrome 0 in this case means bit 7 was wrong, so the data is unchanged. Mark the nibble corrected.
  - Syndrome ≠ 0, P ok: double error; pass the data uncorrected and mark the nibble uncorrectable.
- Assembler: nibble k is placed at bits [4k+3:4k]. Per-word flags are the OR of the per-nibble flags. On the DATA_NIBBLES-th nibble, the word is pushed and the nibble count wraps to 0.
- FIFO full with a push: the word is dropped and `overflow` is set. If a pop occurs in the same cycle, the push is accepted instead.
- Empty FIFO: `word_out`, `err_corrected` and `err_uncorrectable` read 0.
- `ena` low: FSM goes to IDLE, the partial word is discarded, and FIFO pops continue to work.

## Timing
- All outputs reset to 0 (`word_valid` = 0, `fifo_count` = 0).
- Stop bit sampled at cycle T:
  - Decode and nibble register update at T+1.
  - FIFO write at T+1.
  - `word_valid` and `fifo_count` reflect the write at T+2.
  - `frame_err` pulses at T+1.
- Outputs are combinational from the FIFO head. A pop at cycle C exposes the next entry at C+1.
- Back-to-back frames: a start edge is accepted in the cycle after the stop sample.
- Reset mid-frame: FSM, assembler and FIFO all clear. No `frame_err` is raised.

## Structure
- Package `uart_secded_pkg`:
  - FSM state enum.
  - `code_w(EXTENDED)` width function.
  - `hamming_syndrome` function.
  - `secded_classify` function, returning a clean/corrected/uncorrectable enum.
- Sub-module `rx_word_fifo`: a synchronous FIFO, `W+2` bits wide and `FIFO_DEPTH` deep, with count output and simultaneous push/pop.

## Test plan
Default parameters (CLKS_PER_BIT=8, EXTENDED=1, DATA_NIBBLES=2, FIFO_DEPTH=4) unless noted.
- Clean word: send frames 0xD2 then 0x2D, `word_ready`=1 → `word_out`=0x5A, both error flags 0, `word_valid` high for exactly 1 cycle, at T+2 after the second stop sample.
- Single error: send 0xC2 (0xD2 with bit 4 flipped), then 0x2D → `word_out`=0x5A, `err_corrected`=1. Sending 0x52 (parity bit flipped) also yields 0x5A with `err_corrected`=1.
- Double error: send 0xD1, then 0x2D → `err_uncorrectable`=1, `err_corrected`=0. Repeating with EXTENDED=0 and frames 0x52/0x2D yields 0x5A with no flags.
- Framing: send 0xD2 with stop bit 0 → `frame_err` pulses once, nothing is pushed. A following 0xD2, 0x2D yields 0x5A, which proves the assembler reset.
- Overflow and ordering: with `word_ready`=0, send 5 words 0x5A, 0x11, 0x22, 0x33, 0x44 → `fifo_count`=4 and `overflow`=1. Raising `word_ready` then pops 0x5A, 0x11, 0x22, 0x33, and `overflow` stays 1.
- Reset and glitch: assert `rst_n`=0 mid-DATA → all outputs 0. A 2-cycle low pulse on `rx` produces no frame and no `frame_err`.
